// File: rtl/avaliacao_pkg.sv
// Shared types, 7-segment glyphs and elaboration helpers for the evaluation
// scan display.
package avaliacao_pkg;

  typedef logic [1:0] level_t;

  localparam logic [6:0] GLYPH_L0    = 7'b0001100;
  localparam logic [6:0] GLYPH_L1    = 7'b1111010;
  localparam logic [6:0] GLYPH_L2    = 7'b1111100;
  localparam logic [6:0] GLYPH_L3    = 7'b1110011;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  // Map a history slot to its segment pattern; an empty slot is blank.
  function automatic logic [6:0] level_to_seg(input level_t lvl, input logic vld);
    logic [6:0] g;
    g = GLYPH_BLANK;
    if (vld) begin
      case (lvl)
        2'd0:    g = GLYPH_L0;
        2'd1:    g = GLYPH_L1;
        2'd2:    g = GLYPH_L2;
        2'd3:    g = GLYPH_L3;
        default: g = GLYPH_BLANK;
      endcase
    end else begin
      g = GLYPH_BLANK;
    end
    return g;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/avaliacao_scan_display_scan_ctrl.sv
// Digit scan controller: SCAN_DIV-cycle prescaler driving a one-hot digit
// enable that steps from digit 0 upwards and wraps.
module scan_ctrl
  import avaliacao_pkg::*;
#(
  parameter int N_DIG    = 4,
  parameter int SCAN_DIV = 1000,
  parameter int IDX_W    = (N_DIG > 1) ? clog2(N_DIG) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [N_DIG-1:0] dig_en,
  output logic [IDX_W-1:0] dig_idx,
  output logic             advance
);

  localparam int               CNT_W    = (SCAN_DIV > 1) ? clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_DIG-1:0] dig_en_q, dig_en_d;
  logic             adv_s;

  // Prescaler wrap moves the enable to the next digit.
  always_comb begin
    adv_s    = (cnt_q == CNT_LAST);
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dig_en_d = '0;
    if (adv_s) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end
    dig_en_d[idx_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      dig_en_q <= N_DIG'(1);
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dig_en_q <= dig_en_d;
    end
  end

  assign dig_en  = dig_en_q;
  assign dig_idx = idx_q;
  assign advance = adv_s;

endmodule

// File: rtl/avaliacao_scan_display.sv
// Pipelined evaluation level (popcount of flags scaled and added to the base
// code, saturated at 3) with an N_DIG-deep history shown on a scanned display.
module avaliacao_scan_display
  import avaliacao_pkg::*;
#(
  parameter int P_W      = 4,
  parameter int P_DIV    = 2,
  parameter int N_DIG    = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       e,
  input  logic [P_W-1:0]   p,
  input  logic             hold,
  input  logic             clr,
  output logic [1:0]       level,
  output logic             level_valid,
  output logic [6:0]       seg,
  output logic [N_DIG-1:0] dig_en
);

  localparam int               CNT_W    = clog2(P_W + 1);
  localparam int               IDX_W    = (N_DIG > 1) ? clog2(N_DIG) : 1;
  localparam int               SUM_W    = CNT_W + 2;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);

  logic                  accept_s;
  logic                  v1_q, v1_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  level_t                e1_q, e1_d;
  logic [SUM_W-1:0]      sum_s;
  level_t                new_lvl_s;
  level_t                level_q, level_d;
  logic                  lv_q, lv_d;
  level_t [N_DIG-1:0]    hist_lvl_q, hist_lvl_d;
  logic [N_DIG-1:0]      hist_vld_q, hist_vld_d;
  logic [6:0]            seg_q, seg_d;
  logic [IDX_W-1:0]      cur_idx_s, nxt_idx_s;
  logic                  adv_s;

  assign in_ready = ~hold;
  assign accept_s = in_valid & ~hold;

  // Stage 1 captures the flag popcount and base code of an accepted sample.
  always_comb begin
    v1_d = accept_s;
    if (accept_s) begin
      cnt_d = '0;
      for (int i = 0; i < P_W; i++) begin
        cnt_d = cnt_d + CNT_W'(p[i]);
      end
      e1_d = e;
    end else begin
      cnt_d = cnt_q;
      e1_d  = e1_q;
    end
  end

  // Stage 2 saturates the level and shifts it into the history unless cleared.
  always_comb begin
    sum_s     = SUM_W'(e1_q) + SUM_W'(int'(cnt_q) / P_DIV);
    new_lvl_s = (sum_s > SUM_W'(3)) ? 2'd3 : sum_s[1:0];
    lv_d      = v1_q;
    level_d   = v1_q ? new_lvl_s : level_q;
    hist_lvl_d = hist_lvl_q;
    hist_vld_d = hist_vld_q;
    if (clr) begin
      hist_vld_d = '0;
    end else if (v1_q) begin
      hist_lvl_d[0] = new_lvl_s;
      hist_vld_d[0] = 1'b1;
      for (int k = 1; k < N_DIG; k++) begin
        hist_lvl_d[k] = hist_lvl_q[k-1];
        hist_vld_d[k] = hist_vld_q[k-1];
      end
    end else begin
      hist_lvl_d = hist_lvl_q;
      hist_vld_d = hist_vld_q;
    end
  end

  // seg follows the digit that will be enabled after this edge.
  always_comb begin
    if (adv_s) begin
      nxt_idx_s = (cur_idx_s == IDX_LAST) ? '0 : cur_idx_s + IDX_W'(1);
    end else begin
      nxt_idx_s = cur_idx_s;
    end
    seg_d = level_to_seg(hist_lvl_q[nxt_idx_s], hist_vld_q[nxt_idx_s]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      cnt_q      <= '0;
      e1_q       <= '0;
      level_q    <= '0;
      lv_q       <= 1'b0;
      hist_lvl_q <= '0;
      hist_vld_q <= '0;
      seg_q      <= GLYPH_BLANK;
    end else begin
      v1_q       <= v1_d;
      cnt_q      <= cnt_d;
      e1_q       <= e1_d;
      level_q    <= level_d;
      lv_q       <= lv_d;
      hist_lvl_q <= hist_lvl_d;
      hist_vld_q <= hist_vld_d;
      seg_q      <= seg_d;
    end
  end

  scan_ctrl #(
    .N_DIG    (N_DIG),
    .SCAN_DIV (SCAN_DIV),
    .IDX_W    (IDX_W)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .dig_en  (dig_en),
    .dig_idx (cur_idx_s),
    .advance (adv_s)
  );

  assign level       = level_q;
  assign level_valid = lv_q;
  assign seg         = seg_q;

endmodule

// File: tb/tb_avaliacao_scan_display.sv
// Scoreboard bench for avaliacao_scan_display with P_W=4, P_DIV=2, N_DIG=4,
// SCAN_DIV=4.
module tb_avaliacao_scan_display;

  localparam int P_W = 4;
  localparam int N_DIG = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       e;
  logic [P_W-1:0]   p;
  logic             hold;
  logic             clr;
  logic [1:0]       level;
  logic             level_valid;
  logic [6:0]       seg;
  logic [N_DIG-1:0] dig_en;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  localparam logic [6:0] G0 = 7'b0001100;
  localparam logic [6:0] G1 = 7'b1111010;
  localparam logic [6:0] G2 = 7'b1111100;
  localparam logic [6:0] G3 = 7'b1110011;

  avaliacao_scan_display #(
    .P_W(4), .P_DIV(2), .N_DIG(4), .SCAN_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .e(e), .p(p), .hold(hold), .clr(clr), .level(level),
    .level_valid(level_valid), .seg(seg), .dig_en(dig_en)
  );

  always #5 clk = ~clk;

  task automatic chk_value(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample for one edge and record its expected level.
  task automatic drive(input logic [1:0] ev, input logic [P_W-1:0] pv);
    int s;
    s = int'(ev) + $countones(pv) / 2;
    if (s > 3) s = 3;
    exp_q.push_back(s);
    in_valid = 1'b1;
    e = ev;
    p = pv;
    tick();
  endtask

  task automatic check_blank_scan(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk_value(tag, int'(seg), 0);
      tick();
    end
  endtask

  // Scoreboard: every level_valid pulse must match the oldest expected level.
  always @(negedge clk) begin
    if (level_valid) begin
      if (exp_q.size() == 0) begin
        chk_value("lv_unexpected", 1, 0);
      end else begin
        chk_value("level_sb", int'(level), exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [6:0]       exp_seg [N_DIG];
    int               dcount  [N_DIG];
    logic [N_DIG-1:0] prev;
    int               found;
    int               idx;

    rst = 1'b1; in_valid = 1'b0; e = 2'd0; p = '0; hold = 1'b0; clr = 1'b0;
    tick();
    tick();
    chk_value("rst_level", int'(level), 0);
    chk_value("rst_lv", int'(level_valid), 0);
    chk_value("rst_dig_en", int'(dig_en), 1);
    chk_value("rst_seg", int'(seg), 0);
    rst = 1'b0;
    tick();

    // Level computation with exact 2-cycle latency
    drive(2'b01, 4'b1011);
    in_valid = 1'b0;
    chk_value("lat_t0", int'(level_valid), 0);
    tick();
    chk_value("lat_lv", int'(level_valid), 1);
    chk_value("lat_level", int'(level), 2);
    tick();
    chk_value("lat_pulse_end", int'(level_valid), 0);
    drive(2'b11, 4'b1111);
    in_valid = 1'b0;
    tick();
    chk_value("sat_level", int'(level), 3);
    drive(2'b00, 4'b0001);
    in_valid = 1'b0;
    tick();
    chk_value("zero_level", int'(level), 0);
    tick();

    // hold blocks new acceptance but lets the in-flight sample finish
    drive(2'b01, 4'b0011);
    hold = 1'b1;
    e = 2'b11;
    p = 4'b1111;
    #1;
    chk_value("hold_ready", int'(in_ready), 0);
    tick();
    chk_value("hold_lv", int'(level_valid), 1);
    chk_value("hold_level", int'(level), 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_value("hold_no_lv", int'(level_valid), 0);
    end
    in_valid = 1'b0;
    hold = 1'b0;
    #1;
    chk_value("unhold_ready", int'(in_ready), 1);
    tick();

    // Back-to-back stream of levels 0..3 then a full display scan
    drive(2'd0, 4'b0000);
    drive(2'd1, 4'b0000);
    drive(2'd2, 4'b0000);
    drive(2'd3, 4'b0000);
    in_valid = 1'b0;
    tick();
    tick();
    exp_seg[0] = G3; exp_seg[1] = G2; exp_seg[2] = G1; exp_seg[3] = G0;
    for (int i = 0; i < N_DIG; i++) dcount[i] = 0;
    prev = dig_en;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      tick();
      if (dig_en == 4'b0001 && prev == 4'b1000) found = 1;
      prev = dig_en;
    end
    chk_value("scan_sync", found, 1);
    for (int c = 0; c < 16; c++) begin
      idx = 0;
      for (int i = 0; i < N_DIG; i++) if (dig_en[i]) idx = i;
      chk_value("scan_onehot", int'($onehot(dig_en)), 1);
      chk_value("scan_seg", int'(seg), int'(exp_seg[idx]));
      dcount[idx]++;
      tick();
    end
    for (int i = 0; i < N_DIG; i++) chk_value("scan_dwell", dcount[i], 4);

    // clr collides with a stage-2 write of level 2
    drive(2'd2, 4'b0000);
    in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_value("clr_lv", int'(level_valid), 1);
    chk_value("clr_level", int'(level), 2);
    tick();
    check_blank_scan("clr_blank");

    // Reset one cycle after acceptance discards the sample and history
    drive(2'd3, 4'b0000);
    in_valid = 1'b0;
    tick();
    tick();
    drive(2'd1, 4'b0000);
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk_value("mrst_lv", int'(level_valid), 0);
    chk_value("mrst_dig_en", int'(dig_en), 1);
    chk_value("mrst_seg", int'(seg), 0);
    rst = 1'b0;
    tick();
    chk_value("mrst_lv2", int'(level_valid), 0);
    check_blank_scan("mrst_blank");

    chk_value("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
